seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clock cycles each digit stays lit; legal range 2..2^20.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port load  input  1  capture strobe for value, sampled each clk edge.
REQ-005 SHALL have port value  input  32  eight hex digits to display; digit k = value[4k+3:4k].
REQ-006 SHALL have port digit_en  input  8  per-digit enable mask, 1 = digit may light.
REQ-007 SHALL have port blank_lz  input  1  1 = blank leading-zero digits.
REQ-008 SHALL have port cnt_data  output  4  nibble of the active digit, fed to the hex-to-7-segment decoder.
REQ-009 SHALL have port an  output  8  active-low digit anodes, at most one bit low.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when a full 8-digit scan completes.

Function
REQ-011 SHALL hold a divider counter div_cnt counting 0..SCAN_DIV-1; tick asserted when div_cnt==SCAN_DIV-1, next div_cnt = 0.
REQ-012 SHALL hold a 3-bit digit index idx incremented on tick, wrapping 7->0.
REQ-013 SHALL hold pending register pend_val and flag pend: load=1 -> pend_val<=value, pend<=1; a later load overwrites pend_val.
REQ-014 SHALL hold display register disp_val, updated only at frame wrap (tick with idx==7): disp_val<=pend_val if pend, then pend<=0. This gives tear-free updates.
REQ-015 SHALL, when load=1 on the same cycle as frame wrap, load value directly into disp_val and leave pend=0.
REQ-016 SHALL register cnt_data <= disp_val nibble selected by idx on every clk edge (one-cycle latency from idx/disp_val change).
REQ-017 SHALL define digit k as blanked when blank_lz=1, k>0, and disp_val nibbles k..7 are all zero; digit 0 is never blanked.
REQ-018 SHALL register an <= ~(8'b1 << idx) when digit idx is enabled and not blanked, else 8'hFF. Uses the same timing as cnt_data.
REQ-019 SHALL assert frame_done (registered) for exactly one cycle, on the cycle after the 7->0 wrap tick.
REQ-020 SHALL keep scanning continuously; the load, digit_en and blank_lz inputs never stall or reset the divider or idx.
REQ-021 SHALL update digit_en and blank_lz effects within one cycle (no frame synchronisation).

Reset
REQ-022 SHALL, while rst_n=0, immediately force div_cnt=0, idx=0, pend_val=0, pend=0, disp_val=0, cnt_data=4'h0, an=8'hFF, frame_done=0.
REQ-023 SHALL ignore load while rst_n=0. Reset asserted mid-frame discards any pending value.
REQ-024 SHALL resume with digit 0 on the first clk edge after rst_n deasserts: div_cnt 0->1, an=8'hFE if digit_en[0]=1.

Verification (SCAN_DIV=4)
REQ-025 SHALL cover: reset release, digit_en=8'hFF, blank_lz=0, no load -> an sequence FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles, cnt_data=0; frame_done pulses once every 32 cycles.
REQ-026 SHALL cover: load value=32'h89ABCDEF mid-frame -> cnt_data stays 0 until the frame wraps, then shows F,E,D,C,B,A,9,8 for digits 0..7.
REQ-027 SHALL cover: load on the exact wrap cycle with 32'h12345678 -> the next frame shows 8,7,6,...,1 and pend=0 afterwards.
REQ-028 SHALL cover: disp_val=32'h000000A0, blank_lz=1 -> only digits 0,1 light (an=FE,FD), digits 2..7 show an=FF; blank_lz=0 lights all eight.
REQ-029 SHALL cover: digit_en=8'h0F -> digits 4..7 produce an=FF while the scan timing and frame_done are unchanged.
REQ-030 SHALL cover: rst_n pulsed low mid-scan with pend=1 -> outputs return to reset values asynchronously; after release disp_val=0 and the pending value is lost.

Source files
------------

// File: rtl/seg_scan.sv
// seg_scan: 8-digit multiplexed hex display scanner with frame-synchronous
// (tear-free) value updates, per-digit enables and leading-zero blanking.
module seg_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] value,
    input  logic [7:0]  digit_en,
    input  logic        blank_lz,
    output logic [3:0]  cnt_data,
    output logic [7:0]  an,
    output logic        frame_done
);
    localparam int DW = $clog2(SCAN_DIV);
    logic [DW-1:0] r_div_cnt;
    logic [2:0]    r_idx;
    logic [31:0]   r_pend_val;
    logic [31:0]   r_disp_val;
    logic          r_pend;
    logic          w_tick;
    logic          w_wrap;
    logic          w_blank;
    assign w_tick  = r_div_cnt == DW'(SCAN_DIV - 1);
    assign w_wrap  = w_tick && r_idx == 3'd7;
    // a digit is a leading zero when it and every more significant nibble is zero
    assign w_blank = blank_lz && r_idx != 3'd0 && (r_disp_val >> {r_idx, 2'b00}) == 32'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt  <= '0;
            r_idx      <= '0;
            r_pend_val <= '0;
            r_pend     <= 1'b0;
            r_disp_val <= '0;
            cnt_data   <= 4'h0;
            an         <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            r_div_cnt  <= w_tick ? '0 : r_div_cnt + DW'(1);
            r_idx      <= r_idx + 3'(w_tick);
            if (load) r_pend_val <= value;
            r_pend     <= w_wrap ? 1'b0 : (r_pend | load);
            if (w_wrap && load) r_disp_val <= value;
            else if (w_wrap && r_pend) r_disp_val <= r_pend_val;
            cnt_data   <= r_disp_val[{r_idx, 2'b00} +: 4];
            an         <= (digit_en[r_idx] && !w_blank) ? ~(8'b1 << r_idx) : 8'hFF;
            frame_done <= w_wrap;
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: randomized scoreboard bench; a cycle-indexed reference model
// queues expected outputs, a negedge monitor pops and compares them.
module tb_seg_scan;
    localparam int SD = 4;
    localparam int FR = 8 * SD;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  digit_en = 8'hFF;
    logic        blank_lz = 1'b0;
    logic [3:0]  cnt_data;
    logic [7:0]  an;
    logic        frame_done;
    int passed = 0;
    int total = 0;
    logic [12:0] exp_q[$];
    int          n;
    logic [31:0] m_disp;
    logic [31:0] m_pend_val;
    logic        m_pend;

    seg_scan #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .digit_en(digit_en), .blank_lz(blank_lz),
        .cnt_data(cnt_data), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    endtask

    // Reference: edge n (counted from reset release) shows digit (n/SD)%8;
    // the frame wraps on edges where n%FR == FR-1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            m_disp = '0;
            m_pend = 1'b0;
            m_pend_val = '0;
            exp_q.delete();
        end else begin : model
            int k;
            logic [7:0] a;
            logic wrap;
            k = (n / SD) % 8;
            wrap = (n % FR) == FR - 1;
            a = (digit_en[k] && !(blank_lz && k > 0 && (m_disp >> (4 * k)) == 32'd0))
                ? ~(8'b1 << k) : 8'hFF;
            exp_q.push_back({m_disp[4*k +: 4], a, wrap});
            if (wrap) begin
                if (load) m_disp = value;
                else if (m_pend) m_disp = m_pend_val;
                m_pend = 1'b0;
            end else if (load) begin
                m_pend_val = value;
                m_pend = 1'b1;
            end
            n++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin : mon
            logic [12:0] e;
            e = exp_q.pop_front();
            chk("cnt_data", 32'(cnt_data), 32'(e[12:9]));
            chk("an", 32'(an), 32'(e[8:1]));
            chk("frame_done", 32'(frame_done), 32'(e[0]));
        end
    end

    task automatic cyc(input int c);
        repeat (c) @(negedge clk);
    endtask

    task automatic do_load(input logic [31:0] v);
        @(negedge clk);
        load = 1'b1;
        value = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic reset_check();
        #1;
        chk("rst_cnt_data", 32'(cnt_data), 32'h0);
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        reset_check();
        cyc(2);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_wrap(input string name);
        int w = 0;
        @(negedge clk);
        while ((n % FR) != FR - 1 && w < 2 * FR) begin
            @(negedge clk);
            w++;
        end
        chk(name, 32'(w < 2 * FR), 32'h1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        reset_check();
        cyc(2);
        #2 rst_n = 1'b1;
        cyc(70);
        cyc(10);
        do_load(32'h89ABCDEF);
        cyc(70);
        wait_wrap("wrap_found_a");
        load = 1'b1;
        value = 32'h12345678;
        @(negedge clk);
        load = 1'b0;
        cyc(70);
        do_load(32'h000000A0);
        blank_lz = 1'b1;
        cyc(2 * FR + 10);
        blank_lz = 1'b0;
        cyc(FR);
        digit_en = 8'h0F;
        cyc(FR + 5);
        digit_en = 8'hFF;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            load = $urandom_range(0, 7) == 0;
            value = $urandom >> (4 * $urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom);
            blank_lz = 1'($urandom_range(0, 1));
        end
        load = 1'b0;
        digit_en = 8'hFF;
        blank_lz = 1'b0;
        wait_wrap("wrap_found_b");
        cyc(3);
        do_load(32'hDEADBEEF);
        cyc(5);
        do_reset();
        cyc(3 * FR);
        cyc(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
